// File: rtl/systolic_result_axis_tx.sv
// Drains a captured systolic result matrix as one row-major AXI4-Stream frame.
// Define RESULT_PACK_EN to pack two sign-extended 16-bit elements per beat.
module systolic_result_axis_tx #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [SIZE*SIZE*3*DATA_WIDTH-1:0]     result_matrix,
  input  logic                                  capture,
  output logic [31:0]                           m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic                                  busy,
  output logic                                  overrun,
  input  logic                                  overrun_clr
);

  localparam int unsigned RW    = 3 * DATA_WIDTH;
  localparam int unsigned NELEM = SIZE * SIZE;
  localparam int unsigned MW    = NELEM * RW;
`ifdef RESULT_PACK_EN
  localparam int unsigned BEATS = NELEM / 2;
`else
  localparam int unsigned BEATS = NELEM;
`endif
  localparam int unsigned IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef RESULT_PACK_EN
  if ((NELEM % 2) != 0) begin : g_odd_elems
    $error("systolic_result_axis_tx: SIZE*SIZE must be even when packing");
  end
`endif

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [MW-1:0]     shadow_q, shadow_d;
  logic [31:0]       tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              hs, last_hs, accept;
  int unsigned       base;
  logic [31:0]       beat;

  // Next-state, shadow load and registered-output precomputation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    overrun_d = overrun_q;
    hs        = tvalid_q & m_axis_tready;
    last_hs   = hs & tlast_q;
    accept    = capture & ((state_q == IDLE) | last_hs);

    case (state_q)
      IDLE: begin
        if (accept) state_d = SEND;
      end
      SEND: begin
        if (last_hs) begin
          if (!accept) state_d = IDLE;
          idx_d = '0;
        end else if (hs) begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      shadow_d = result_matrix;
      idx_d    = '0;
    end

    // A same-cycle set beats the clear.
    if (overrun_clr) overrun_d = 1'b0;
    if (capture && !accept) overrun_d = 1'b1;

`ifdef RESULT_PACK_EN
    base = 32'(idx_d) * 2 * RW;
    beat = {16'($signed(shadow_d[base + RW +: RW])), 16'($signed(shadow_d[base +: RW]))};
`else
    base = 32'(idx_d) * RW;
    beat = 32'($signed(shadow_d[base +: RW]));
`endif

    tvalid_d = (state_d == SEND);
    busy_d   = (state_d == SEND);
    tlast_d  = (state_d == SEND) && (idx_d == IDXW'(BEATS - 1));
    tdata_d  = (state_d == SEND) ? beat : 32'd0;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule
